easyaxi_rd_link: RTL and testbench



---
 rtl/easyaxi_rd_link.sv | 164 ++++++++++++++++
 tb/tb_easyaxi_rd_link.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/easyaxi_rd_link.sv
// rtl/easyaxi_rd_link.sv - AR/R read-path link: skid buffers, outstanding-burst gate, rlast error flag
// Optional statistics counters: EASYAXI_RD_LINK_STAT_EN
module easyaxi_rd_link_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic [W-1:0] q0;
    logic [W-1:0] q1;
    logic         push;
    logic         pop;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = q0;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // q0 is the head; a push lands in q1 only when it queues behind a remaining head
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            count     <= count_nxt;
            in_ready  <= (count_nxt != 2'd2);
            out_valid <= (count_nxt != 2'd0);
            if (pop)
                q0 <= q1;
            if (push) begin
                if (count_nxt == 2'd2)
                    q1 <= in_data;
                else
                    q0 <= in_data;
            end
        end
    end
endmodule

module easyaxi_rd_link #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int DATA_W  = 64,
    parameter int MAX_OST = 4,
    localparam int CW     = $clog2(MAX_OST + 1),
    localparam int ARW    = ID_W + ADDR_W + LEN_W + 5,
    localparam int RW     = ID_W + DATA_W + 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_arvalid,
    output logic           s_arready,
    input  logic [ARW-1:0] s_ar,
    output logic           m_arvalid,
    input  logic           m_arready,
    output logic [ARW-1:0] m_ar,
    input  logic           m_rvalid,
    output logic           m_rready,
    input  logic [RW-1:0]  m_r,
    input  logic           m_rlast,
    output logic           s_rvalid,
    input  logic           s_rready,
    output logic [RW-1:0]  s_r,
    output logic           s_rlast,
    output logic [CW-1:0]  ost_cnt,
    output logic           err_rlast,
    output logic [31:0]    stat_ar,
    output logic [31:0]    stat_rlast
);
    logic          ar_in_ready;
    logic          ost_ok;
    logic          ar_hs;
    logic          rlast_hs;
    logic [CW-1:0] ost_nxt;

    assign s_arready = ar_in_ready && ost_ok;
    assign ar_hs     = s_arvalid && s_arready;
    assign rlast_hs  = s_rvalid && s_rready && s_rlast;

    easyaxi_rd_link_skid #(.W(ARW)) u_ar_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_arvalid && ost_ok),
        .in_ready  (ar_in_ready),
        .in_data   (s_ar),
        .out_valid (m_arvalid),
        .out_ready (m_arready),
        .out_data  (m_ar)
    );

    easyaxi_rd_link_skid #(.W(RW + 1)) u_r_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (m_rvalid),
        .in_ready  (m_rready),
        .in_data   ({m_r, m_rlast}),
        .out_valid (s_rvalid),
        .out_ready (s_rready),
        .out_data  ({s_r, s_rlast})
    );

    always_comb begin
        ost_nxt = ost_cnt;
        if (ar_hs && !rlast_hs)
            ost_nxt = ost_cnt + CW'(1);
        else if (rlast_hs && !ar_hs && ost_cnt != '0)
            ost_nxt = ost_cnt - CW'(1);
    end

    // ost_ok is kept as its own flop so s_arready never sees the R-side handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            ost_cnt   <= '0;
            ost_ok    <= 1'b1;
            err_rlast <= 1'b0;
        end else begin
            ost_cnt <= ost_nxt;
            ost_ok  <= (ost_nxt < CW'(MAX_OST));
            if (rlast_hs && ost_cnt == '0)
                err_rlast <= 1'b1;
        end
    end

`ifdef EASYAXI_RD_LINK_STAT_EN
    logic [31:0] stat_ar_q;
    logic [31:0] stat_rlast_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ar_q    <= 32'd0;
            stat_rlast_q <= 32'd0;
        end else begin
            if (ar_hs)
                stat_ar_q <= stat_ar_q + 32'd1;
            if (rlast_hs)
                stat_rlast_q <= stat_rlast_q + 32'd1;
        end
    end

    assign stat_ar    = stat_ar_q;
    assign stat_rlast = stat_rlast_q;
`else
    assign stat_ar    = 32'd0;
    assign stat_rlast = 32'd0;
`endif
endmodule

// File: tb/tb_easyaxi_rd_link.sv
// tb/tb_easyaxi_rd_link.sv - self-checking bench for easyaxi_rd_link (vector table, directed, random vs model)
module tb_easyaxi_rd_link;
    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 8;
    localparam int DATA_W  = 64;
    localparam int MAX_OST = 4;
    localparam int CW      = $clog2(MAX_OST + 1);
    localparam int ARW     = ID_W + ADDR_W + LEN_W + 5;
    localparam int RW      = ID_W + DATA_W + 2;

    logic           clk;
    logic           rst;
    logic           s_arvalid;
    logic           s_arready;
    logic [ARW-1:0] s_ar;
    logic           m_arvalid;
    logic           m_arready;
    logic [ARW-1:0] m_ar;
    logic           m_rvalid;
    logic           m_rready;
    logic [RW-1:0]  m_r;
    logic           m_rlast;
    logic           s_rvalid;
    logic           s_rready;
    logic [RW-1:0]  s_r;
    logic           s_rlast;
    logic [CW-1:0]  ost_cnt;
    logic           err_rlast;
    logic [31:0]    stat_ar;
    logic [31:0]    stat_rlast;

    int n_cmp = 0;
    int n_bad = 0;

    easyaxi_rd_link #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .MAX_OST(MAX_OST)
    ) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar(m_ar),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r(m_r), .m_rlast(m_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r), .s_rlast(s_rlast),
        .ost_cnt(ost_cnt), .err_rlast(err_rlast),
        .stat_ar(stat_ar), .stat_rlast(stat_rlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic arv, mar, rv, rl, srr;
        logic e_ary, e_mav, e_srv;
        int   e_ost;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        s_arvalid = 1'b0; s_ar = '0; m_arready = 1'b0;
        m_rvalid = 1'b0; m_r = '0; m_rlast = 1'b0; s_rready = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [RW-1:0] beat(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
        return {id, d, 2'b00};
    endfunction

    // reference model: occupancy queues and burst counts derived from observed handshakes
    logic [ARW-1:0] arq[$];
    logic [RW:0]    rq[$];
    int             mo;
    logic           me;
    logic [31:0]    msa, msr;

    task automatic model_cycle;
        logic arhs, rlhs;
        chk("rnd_m_arvalid", m_arvalid, arq.size() > 0);
        if (arq.size() > 0) chk("rnd_m_ar", m_ar, arq[0]);
        chk("rnd_s_arready", s_arready, (arq.size() < 2) && (mo < MAX_OST));
        chk("rnd_m_rready", m_rready, rq.size() < 2);
        chk("rnd_s_rvalid", s_rvalid, rq.size() > 0);
        if (rq.size() > 0) chk("rnd_s_r", {s_r, s_rlast}, rq[0]);
        chk("rnd_ost", ost_cnt, mo);
        chk("rnd_err", err_rlast, me);
        chk("rnd_stat_ar", stat_ar, msa);
        chk("rnd_stat_rlast", stat_rlast, msr);
        arhs = s_arvalid && s_arready;
        rlhs = s_rvalid && s_rready && s_rlast;
        if (m_arvalid && m_arready) void'(arq.pop_front());
        if (arhs) arq.push_back(s_ar);
        if (s_rvalid && s_rready) void'(rq.pop_front());
        if (m_rvalid && m_rready) rq.push_back({m_r, m_rlast});
        if (rlhs && mo == 0) me = 1'b1;
        if (arhs && !rlhs) mo++;
        else if (rlhs && !arhs && mo > 0) mo--;
`ifdef EASYAXI_RD_LINK_STAT_EN
        msa += 32'(arhs);
        msr += 32'(rlhs);
`endif
    endtask

    initial begin
        logic [ARW-1:0]    pay;
        logic [DATA_W-1:0] got[$];
        int                sent;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4};

        // single AR plus a 4-beat burst, reset values
        do_reset();
        @(negedge clk);
        chk("rst_s_arready", s_arready, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_s_rvalid", s_rvalid, 0);
        chk("rst_ost", ost_cnt, 0);
        chk("rst_err", err_rlast, 0);
        chk("rst_stat_ar", stat_ar, 0);
        chk("rst_stat_rlast", stat_rlast, 0);
        tick();
        pay = {4'd3, 32'h1000, 8'd3, 3'd3, 2'd1};
        s_arvalid = 1'b1; s_ar = pay; m_arready = 1'b1;
        @(negedge clk);
        chk("t1_s_arready", s_arready, 1);
        chk("t1_m_arvalid_pre", m_arvalid, 0);
        tick();
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("t1_m_arvalid", m_arvalid, 1);
        chk("t1_m_ar", m_ar, pay);
        chk("t1_ost1", ost_cnt, 1);
        tick();
        @(negedge clk);
        chk("t1_m_arvalid_post", m_arvalid, 0);
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1; m_r = beat(4'd3, 64'h100 + 64'(b)); m_rlast = (b == 3); s_rready = 1'b1;
            @(negedge clk);
            chk("t1_m_rready", m_rready, 1);
            if (b > 0) begin
                chk("t1_s_rvalid", s_rvalid, 1);
                chk("t1_s_r", s_r, beat(4'd3, 64'h100 + 64'(b - 1)));
                chk("t1_s_rlast", s_rlast, 0);
            end
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clk);
        chk("t1_s_rvalid_last", s_rvalid, 1);
        chk("t1_s_r_last", s_r, beat(4'd3, 64'h103));
        chk("t1_s_rlast_last", s_rlast, 1);
        chk("t1_ost_before", ost_cnt, 1);
        tick();
        @(negedge clk);
        chk("t1_ost0", ost_cnt, 0);
        chk("t1_s_rvalid_done", s_rvalid, 0);

        // outstanding gate, vector table starting in the first cycle after reset
        do_reset();
        for (int i = 0; i < 11; i++) begin
            s_arvalid = tbl[i].arv; s_ar = ARW'(i); m_arready = tbl[i].mar;
            m_rvalid = tbl[i].rv; m_r = beat(4'd1, 64'(i)); m_rlast = tbl[i].rl; s_rready = tbl[i].srr;
            @(negedge clk);
            chk($sformatf("gate%0d_s_arready", i), s_arready, tbl[i].e_ary);
            chk($sformatf("gate%0d_m_arvalid", i), m_arvalid, tbl[i].e_mav);
            chk($sformatf("gate%0d_s_rvalid", i), s_rvalid, tbl[i].e_srv);
            chk($sformatf("gate%0d_ost", i), ost_cnt, tbl[i].e_ost);
            tick();
        end

        // R backpressure: two beats absorbed, then release and drain in order
        do_reset();
        tick();
        sent = 0;
        got.delete();
        for (int c = 0; c < 30; c++) begin
            m_rvalid = (sent < 5); m_r = beat(4'd0, 64'hA0 + 64'(sent)); m_rlast = 1'b0;
            s_rready = (c >= 6);
            @(negedge clk);
            if (c < 2) chk("bp_rready_open", m_rready, 1);
            if (c >= 2 && c < 6) chk("bp_rready_held", m_rready, 0);
            if (m_rvalid && m_rready) sent++;
            if (s_rvalid && s_rready) got.push_back(s_r[DATA_W+1:2]);
            tick();
        end
        chk("bp_count", got.size(), 5);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("bp_data%0d", i), got[i], 64'hA0 + 64'(i));

        // simultaneous AR accept and burst completion
        do_reset();
        tick();
        s_arvalid = 1'b1; m_arready = 1'b1;
        tick();
        tick();
        s_arvalid = 1'b0; m_rvalid = 1'b1; m_r = beat(4'd2, 64'h55); m_rlast = 1'b1; s_rready = 1'b0;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b1; s_arvalid = 1'b1;
        @(negedge clk);
        chk("both_s_rvalid", s_rvalid, 1);
        chk("both_s_rlast", s_rlast, 1);
        chk("both_s_arready", s_arready, 1);
        chk("both_ost_before", ost_cnt, 2);
        tick();
        s_arvalid = 1'b0; s_rready = 1'b0;
        @(negedge clk);
        chk("both_ost_after", ost_cnt, 2);
        chk("both_err", err_rlast, 0);

        // stray rlast with nothing outstanding
        do_reset();
        tick();
        m_rvalid = 1'b1; m_rlast = 1'b1; m_r = beat(4'd7, 64'h77); s_rready = 1'b1;
        @(negedge clk);
        chk("err_m_rready", m_rready, 1);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clk);
        chk("err_s_rvalid", s_rvalid, 1);
        chk("err_pre", err_rlast, 0);
        tick();
        @(negedge clk);
        chk("err_set", err_rlast, 1);
        chk("err_ost", ost_cnt, 0);
        tick();
        tick();
        @(negedge clk);
        chk("err_sticky", err_rlast, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", err_rlast, 0);

        // statistics counters
        do_reset();
        tick();
`ifdef EASYAXI_RD_LINK_STAT_EN
        force dut.stat_ar_q = 32'hFFFF_FFFF;
        release dut.stat_ar_q;
        @(negedge clk);
        chk("stat_preload", stat_ar, 32'hFFFF_FFFF);
        tick();
        s_arvalid = 1'b1; m_arready = 1'b1;
        tick();
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("stat_wrap", stat_ar, 0);
`else
        @(negedge clk);
        chk("stat_ar_zero", stat_ar, 0);
        chk("stat_rlast_zero", stat_rlast, 0);
`endif

        // randomized traffic against the reference model
        do_reset();
        tick();
        arq.delete(); rq.delete();
        mo = 0; me = 1'b0; msa = 32'd0; msr = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            s_arvalid = ($urandom_range(0, 1) == 1);
            s_ar      = ARW'({$urandom(), $urandom()});
            m_arready = ($urandom_range(0, 3) != 0);
            m_rvalid  = ($urandom_range(0, 1) == 1);
            m_r       = RW'({$urandom(), $urandom(), $urandom()});
            m_rlast   = ($urandom_range(0, 3) == 0);
            s_rready  = (c % 200 < 150) ? ($urandom_range(0, 3) != 0) : 1'b0;
            @(negedge clk);
            model_cycle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
